// File: rtl/nr_divider_seq.sv
// rtl/nr_divider_seq.sv - sequential unsigned non-restoring divider with start/done handshake
//
// add_sub: W-bit adder/subtractor, sum = a + b (mode=0) or a - b (mode=1).
//   Only the low W bits are produced; the carry-out is not needed here.
//
// nr_divider_seq ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              request a division, accepted only while idle
//   dividend, divisor  unsigned operands, sampled on the accepting edge
//   busy               high while iterating and correcting
//   done               one-cycle pulse; results valid from this cycle on
//   quotient           registered quotient, held until the next accepted start
//   remainder          registered remainder, held until the next accepted start
//   div_by_zero        registered flag, held with the results

module add_sub #(
    parameter int W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W-1:0] sum
);
    // Two's complement subtract: invert b and inject mode as the carry-in.
    assign sum = a + (b ^ {W{mode}}) + {{(W-1){1'b0}}, mode};
endmodule

module nr_divider_seq #(
    parameter int SIZE = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);
    localparam int RW = SIZE + 2;
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, CORRECT, DONE} state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   r;
    logic [RW-1:0]   d;
    logic [SIZE-1:0] q;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   add_a;
    logic [RW-1:0]   add_sum;
    logic            add_mode;
    logic            r_neg;

    assign r_neg = r[RW-1];

    // RUN feeds the shifted partial remainder and picks subtract/add from
    // the sign of R; CORRECT reuses the same adder to add D back.
    always_comb begin
        add_a    = r;
        add_mode = 1'b0;
        if (state == RUN) begin
            add_a    = {r[SIZE:0], q[SIZE-1]};
            add_mode = ~r_neg;
        end
    end

    add_sub #(.W(RW)) u_add_sub (
        .a    (add_a),
        .b    (d),
        .mode (add_mode),
        .sum  (add_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(SIZE - 1)) begin
                    state_nx = CORRECT;
                end
            end
            CORRECT: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Results are published on this edge, so DONE
                            // follows immediately with no iterations.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r           <= '0;
                            q           <= dividend;
                            d           <= {2'b00, divisor};
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r   <= add_sum;
                    q   <= {q[SIZE-2:0], ~add_sum[RW-1]};
                    cnt <= cnt + CW'(1);
                end
                CORRECT: begin
                    r         <= r_neg ? add_sum : r;
                    quotient  <= q;
                    remainder <= r_neg ? add_sum[SIZE-1:0] : r[SIZE-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nr_divider_seq.sv
// tb/tb_nr_divider_seq.sv - self-checking bench for nr_divider_seq

module tb_nr_divider_seq;
    localparam int SIZE = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [SIZE-1:0] dividend = '0;
    logic [SIZE-1:0] divisor = '0;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            div_by_zero;

    int checks = 0;
    int errors = 0;

    nr_divider_seq #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_k counts cycles since the accepting edge (1 = cycle after it),
    // m_len is the value of m_k in the done cycle. Results from / and %.
    int              m_k = 0;
    int              m_len = 0;
    logic [SIZE-1:0] m_q = '0;
    logic [SIZE-1:0] m_r = '0;
    logic            m_dz = 1'b0;
    logic [SIZE-1:0] p_q = '0;
    logic [SIZE-1:0] p_r = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k   <= 0;
            m_len <= 0;
            m_q   <= '0;
            m_r   <= '0;
            m_dz  <= 1'b0;
        end else if (m_k == 0) begin
            if (start) begin
                m_k <= 1;
                if (divisor == 0) begin
                    m_len <= 1;
                    m_q   <= '1;
                    m_r   <= dividend;
                    m_dz  <= 1'b1;
                end else begin
                    m_len <= SIZE + 2;
                    p_q   <= dividend / divisor;
                    p_r   <= dividend % divisor;
                    m_dz  <= 1'b0;
                end
            end
        end else if (m_k == m_len) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_len) begin
                m_q <= p_q;
                m_r <= p_r;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_k != 0 && m_k < m_len));
        chk("done", 32'(done), 32'(m_k != 0 && m_k == m_len));
        chk("quotient", 32'(quotient), 32'(m_q));
        chk("remainder", 32'(remainder), 32'(m_r));
        chk("div_by_zero", 32'(div_by_zero), 32'(m_dz));
    end

    // Issue one division from idle; returns the cycle index of done
    // (1 = cycle after the accepting edge) and the number of busy cycles.
    task automatic do_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [SIZE-1:0] eq, input logic [SIZE-1:0] er,
                          input logic edz, output int cyc, output int bcnt);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        bcnt = 0;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cyc == 0) begin
                start    = 1'b0;
                dividend = SIZE'($urandom);
                divisor  = SIZE'($urandom);
            end
            cyc++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        chk("done_timeout", 32'(seen), 32'd1);
        chk("res_q", 32'(quotient), 32'(eq));
        chk("res_r", 32'(remainder), 32'(er));
        chk("res_dz", 32'(div_by_zero), 32'(edz));
    endtask

    initial begin
        int cyc, bc, ndone, last;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        do_div(5'd13, 5'd3, 5'd4, 5'd1, 1'b0, cyc, bc);
        chk("done_cycle_13_3", 32'(cyc), 32'd7);
        chk("busy_cycles_13_3", 32'(bc), 32'd6);
        do_div(5'd31, 5'd1, 5'd31, 5'd0, 1'b0, cyc, bc);
        do_div(5'd7, 5'd9, 5'd0, 5'd7, 1'b0, cyc, bc);
        do_div(5'd31, 5'd31, 5'd1, 5'd0, 1'b0, cyc, bc);
        do_div(5'd0, 5'd5, 5'd0, 5'd0, 1'b0, cyc, bc);
        do_div(5'd20, 5'd0, 5'd31, 5'd20, 1'b1, cyc, bc);
        chk("done_cycle_div0", 32'(cyc), 32'd1);
        chk("busy_cycles_div0", 32'(bc), 32'd0);
        do_div(5'd9, 5'd2, 5'd4, 5'd1, 1'b0, cyc, bc);

        // Asynchronous reset in the middle of iteration 3.
        @(negedge clk);
        start    = 1'b1;
        dividend = 5'd25;
        divisor  = 5'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_q", 32'(quotient), 32'd0);
        chk("arst_r", 32'(remainder), 32'd0);
        chk("arst_dz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        do_div(5'd25, 5'd4, 5'd6, 5'd1, 1'b0, cyc, bc);

        // start held high: done every SIZE+3 cycles, each 17/5 = 3 r 2.
        @(negedge clk);
        start    = 1'b1;
        dividend = 5'd17;
        divisor  = 5'd5;
        ndone = 0;
        last  = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("done_interval", 32'(i - last), 32'd8);
                chk("hold_q", 32'(quotient), 32'd3);
                chk("hold_r", 32'(remainder), 32'd2);
                last = i;
                ndone++;
            end
        end
        chk("hold_done_count", 32'(ndone), 32'd5);
        start = 1'b0;
        repeat (12) @(negedge clk);

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                if (b == 0)
                    do_div(SIZE'(a), 5'd0, 5'd31, SIZE'(a), 1'b1, cyc, bc);
                else
                    do_div(SIZE'(a), SIZE'(b), SIZE'(a / b), SIZE'(a % b), 1'b0, cyc, bc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
